// File: rtl/bounce_gen.sv
// Switch bounce emulator. It turns a clean level command into a burst of LFSR-spaced
// toggles and then holds the commanded level for a settle window.
module bounce_gen #(
  parameter int          NB      = 6,
  parameter int          IW      = 8,
  parameter int          MIN_GAP = 4,
  parameter int          SETTLE  = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       level_in,
  output logic       sw_out,
  output logic       busy,
  output logic       settle_tick,
  output logic [7:0] toggle_cnt
);

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] IW_MASK    = 16'((32'd1 << IW) - 32'd1);
  localparam logic [15:0] MIN_GAP_16 = 16'(MIN_GAP);
  localparam logic [15:0] SETTLE_16  = 16'(SETTLE);
  localparam logic [7:0]  LAST_CNT   = 8'(2 * NB + 1);

  typedef enum logic [1:0] {STABLE, BOUNCE, HOLD} state_t;

  state_t      state_q, state_d;
  logic        sw_q, sw_d;
  logic        target_q, target_d;
  logic        busy_q, busy_d;
  logic        tick_q, tick_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] gap;
  logic [15:0] lfsr_next;

  always_comb begin
    gap       = MIN_GAP_16 + (lfsr_q & IW_MASK);
    // Galois step: shift right, fold the mask in when a one falls off the end.
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    state_d   = state_q;
    sw_d      = sw_q;
    target_d  = target_q;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      STABLE: begin
        if (en && (level_in != sw_q)) begin
          sw_d     = level_in;
          target_d = level_in;
          cnt_d    = 8'd1;
          busy_d   = 1'b1;
          if (NB > 0) begin
            gap_cnt_d = gap;
            lfsr_d    = lfsr_next;
            state_d   = BOUNCE;
          end else begin
            gap_cnt_d = SETTLE_16;
            state_d   = HOLD;
          end
        end
      end
      BOUNCE: begin
        if (gap_cnt_q == 16'd1) begin
          sw_d  = ~sw_q;
          cnt_d = cnt_q + 8'd1;
          // The final toggle lands on the target; no further gap is drawn.
          if ((cnt_d == LAST_CNT) && (sw_d == target_q)) begin
            gap_cnt_d = SETTLE_16;
            state_d   = HOLD;
          end else begin
            gap_cnt_d = gap;
            lfsr_d    = lfsr_next;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (gap_cnt_q == 16'd1) begin
          tick_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = STABLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STABLE;
      sw_q      <= 1'b0;
      target_q  <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      cnt_q     <= 8'd0;
      lfsr_q    <= SEED_EFF;
      gap_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      target_q  <= target_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign sw_out      = sw_q;
  assign busy        = busy_q;
  assign settle_tick = tick_q;
  assign toggle_cnt  = cnt_q;

endmodule
